// File: rtl/fifo_stream_reader.sv
// Read-side drain stage for fifo_synch: re-presents FIFO words on a valid/ready stream through a skid buffer.
// Optional feature: define FIFO_STREAM_READER_FLUSH_EN to add a synchronous `flush` input.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
`ifdef FIFO_STREAM_READER_FLUSH_EN
  input  logic                                 flush,
`endif
  input  logic                                 fifo_empty,
  input  logic                                 fifo_wr_busy,
  input  logic [DATA_WIDTH-1:0]                fifo_rd_data,
  output logic                                 fifo_rd_en,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WIDTH-1:0]                m_data,
  output logic [$clog2(SKID_DEPTH+1)-1:0]      occupancy
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [OCC_W:0]   DEPTH = (OCC_W + 1)'(SKID_DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(SKID_DEPTH - 1);

  logic                  inflight;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [DATA_WIDTH-1:0] buffer [SKID_DEPTH];
  logic                  flush_i;
  logic                  rd_acc;
  logic                  push;
  logic                  pop;
  logic [OCC_W:0]        committed;
  logic [OCC_W-1:0]      occ_next;

`ifdef FIFO_STREAM_READER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Count the word already requested so the buffer can never be over-committed.
  assign committed  = {1'b0, occupancy} + {{OCC_W{1'b0}}, inflight};
  assign fifo_rd_en = !reset && !flush_i && !fifo_empty && (committed < DEPTH);
  // The FIFO drops a read in any cycle where it accepts a write.
  assign rd_acc     = fifo_rd_en && !fifo_wr_busy;
  assign push       = inflight;
  assign pop        = m_valid && m_ready;
  assign m_data     = buffer[head];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    occ_next = occupancy;
    if (push && !pop)
      occ_next = occupancy + OCC_W'(1);
    else if (pop && !push)
      occ_next = occupancy - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      m_valid   <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++)
        buffer[i] <= '0;
    end else if (flush_i) begin
      // A word returning this cycle is dropped along with the buffered ones.
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      m_valid   <= 1'b0;
    end else begin
      inflight <= rd_acc;
      if (push) begin
        buffer[tail] <= fifo_rd_data;
        tail         <= next_ptr(tail);
      end
      if (pop)
        head <= next_ptr(head);
      occupancy <= occ_next;
      m_valid   <= (occ_next != '0);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural fifo_synch read-port model and an output scoreboard.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic       fifo_wr_busy;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;
`ifdef FIFO_STREAM_READER_FLUSH_EN
  logic       flush;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;

  logic [7:0] recv [0:127];
  int recv_n = 0;
  int occ_max = 0;

  fifo_stream_reader #(.DATA_WIDTH(8), .SKID_DEPTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef FIFO_STREAM_READER_FLUSH_EN
    .flush        (flush),
`endif
    .fifo_empty   (fifo_empty),
    .fifo_wr_busy (fifo_wr_busy),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO read port: registered data one cycle after an accepted read.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_wr_busy && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
      rd_count     <= rd_count + 1;
    end
  end

  always @(posedge clk) begin
    if (!reset && m_valid && m_ready) begin
      recv[recv_n] <= m_data;
      recv_n       <= recv_n + 1;
    end
    if (int'(occupancy) > occ_max)
      occ_max <= int'(occupancy);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_recv(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (recv_n < target && c < budget) begin
      tick();
      c++;
    end
    check(tag, 32'(recv_n >= target), 32'd1);
  endtask

  int base_r;
  int base_c;

  initial begin
    reset        = 1'b1;
    m_ready      = 1'b0;
    fifo_wr_busy = 1'b0;
`ifdef FIFO_STREAM_READER_FLUSH_EN
    flush        = 1'b0;
`endif
    tick();
    tick();
    check("rst_rd_en",  32'(fifo_rd_en), 32'd0);
    check("rst_valid",  32'(m_valid),    32'd0);
    check("rst_data",   32'(m_data),     32'h00);
    check("rst_occ",    32'(occupancy),  32'd0);

    // 1: preloaded 11/22/33, consumer always ready
    base_r = recv_n; base_c = rd_count;
    push(8'h11); push(8'h22); push(8'h33);
    m_ready = 1'b1;
    reset   = 1'b0;
    #1;
    check("t1_rd_en_c0", 32'(fifo_rd_en), 32'd1);
    check("t1_valid_c0", 32'(m_valid),    32'd0);
    tick(); #1;
    check("t1_rd_en_c1", 32'(fifo_rd_en), 32'd1);
    check("t1_valid_c1", 32'(m_valid),    32'd0);
    tick(); #1;
    check("t1_rd_en_c2", 32'(fifo_rd_en), 32'd1);
    check("t1_valid_c2", 32'(m_valid),    32'd1);
    check("t1_data_c2",  32'(m_data),     32'h11);
    tick(); #1;
    check("t1_rd_en_c3", 32'(fifo_rd_en), 32'd0);
    check("t1_data_c3",  32'(m_data),     32'h22);
    tick(); #1;
    check("t1_valid_c4", 32'(m_valid),    32'd1);
    check("t1_data_c4",  32'(m_data),     32'h33);
    tick(); #1;
    check("t1_valid_c5", 32'(m_valid),    32'd0);
    check("t1_occ_c5",   32'(occupancy),  32'd0);
    check("t1_reads",    32'(rd_count - base_c), 32'd3);
    check("t1_w0", 32'(recv[base_r]),   32'h11);
    check("t1_w1", 32'(recv[base_r+1]), 32'h22);
    check("t1_w2", 32'(recv[base_r+2]), 32'h33);

    // 2: consumer stalled with 5 words queued
    base_r = recv_n; base_c = rd_count;
    m_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    #1;
    check("t2_rd_en_start", 32'(fifo_rd_en), 32'd1);
    tick(); tick(); tick(); tick(); #1;
    check("t2_occ_full",  32'(occupancy), 32'd3);
    check("t2_rd_en_off", 32'(fifo_rd_en), 32'd0);
    check("t2_valid",     32'(m_valid),   32'd1);
    check("t2_data_hold", 32'(m_data),    32'hA1);
    tick(); tick(); #1;
    check("t2_data_hold2", 32'(m_data),   32'hA1);
    check("t2_reads",     32'(rd_count - base_c), 32'd3);
    m_ready = 1'b1;
    wait_recv(base_r + 5, 30, "t2_timeout");
    for (int i = 0; i < 5; i++)
      check("t2_word", 32'(recv[base_r+i]), 32'hA1 + 32'(i));
    check("t2_reads_all", 32'(rd_count - base_c), 32'd5);

    // 3: write collision on the second read cycle
    tick(); tick();
    base_r = recv_n; base_c = rd_count;
    push(8'hB1); push(8'hB2); push(8'hB3);
    #1;
    check("t3_rd_en_c0", 32'(fifo_rd_en), 32'd1);
    tick();
    fifo_wr_busy = 1'b1;
    #1;
    check("t3_rd_en_busy", 32'(fifo_rd_en), 32'd1);
    tick();
    fifo_wr_busy = 1'b0;
    #1;
    check("t3_reads_after_busy", 32'(rd_count - base_c), 32'd1);
    check("t3_occ_after_busy",   32'(occupancy),          32'd1);
    wait_recv(base_r + 3, 20, "t3_timeout");
    tick(); tick(); tick(); tick();
    check("t3_count", 32'(recv_n - base_r), 32'd3);
    check("t3_w0", 32'(recv[base_r]),   32'hB1);
    check("t3_w1", 32'(recv[base_r+1]), 32'hB2);
    check("t3_w2", 32'(recv[base_r+2]), 32'hB3);
    check("t3_reads", 32'(rd_count - base_c), 32'd3);

    // 4: 20 words with alternating consumer ready
    base_r = recv_n;
    for (int i = 0; i < 20; i++)
      push(8'(i));
    for (int c = 0; c < 200 && recv_n < base_r + 20; c++) begin
      m_ready = c[0];
      tick();
    end
    check("t4_timeout", 32'(recv_n >= base_r + 20), 32'd1);
    m_ready = 1'b1;
    tick(); tick(); tick();
    check("t4_count", 32'(recv_n - base_r), 32'd20);
    for (int i = 0; i < 20; i++)
      check("t4_word", 32'(recv[base_r+i]), 32'(i));
    check("t4_occ_max", 32'(occ_max <= 3), 32'd1);

    // 5: reset with two words buffered and one in flight
    base_r = recv_n;
    m_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5);
    tick(); tick(); tick(); #1;
    check("t5_occ_pre", 32'(occupancy), 32'd2);
    check("t5_rd_en_pre", 32'(fifo_rd_en), 32'd0);
    reset = 1'b1;
    tick(); #1;
    check("t5_valid_rst", 32'(m_valid),   32'd0);
    check("t5_occ_rst",   32'(occupancy), 32'd0);
    check("t5_data_rst",  32'(m_data),    32'h00);
    reset   = 1'b0;
    m_ready = 1'b1;
    wait_recv(base_r + 2, 20, "t5_timeout");
    tick(); tick(); tick(); tick();
    check("t5_count", 32'(recv_n - base_r), 32'd2);
    check("t5_w0", 32'(recv[base_r]),   32'hC4);
    check("t5_w1", 32'(recv[base_r+1]), 32'hC5);

`ifdef FIFO_STREAM_READER_FLUSH_EN
    // 6: flush with two words buffered and one in flight
    base_r = recv_n;
    m_ready = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hD5);
    tick(); tick(); tick(); #1;
    check("t6_occ_pre", 32'(occupancy), 32'd2);
    flush = 1'b1;
    #1;
    check("t6_rd_en_flush", 32'(fifo_rd_en), 32'd0);
    tick(); #1;
    flush = 1'b0;
    check("t6_valid_flush", 32'(m_valid),   32'd0);
    check("t6_occ_flush",   32'(occupancy), 32'd0);
    m_ready = 1'b1;
    wait_recv(base_r + 2, 20, "t6_timeout");
    tick(); tick(); tick(); tick();
    check("t6_count", 32'(recv_n - base_r), 32'd2);
    check("t6_w0", 32'(recv[base_r]),   32'hD4);
    check("t6_w1", 32'(recv[base_r+1]), 32'hD5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
